// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int MC_LOAD  = 1;
    localparam int MC_STORE = 0;
    localparam int AW       = 16;
    localparam int DW       = 16;

    function automatic int off_w(input int words_per_blk);
        return $clog2(words_per_blk);
    endfunction

    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Byte address minus the ignored byte bit, word offset and index.
    function automatic int tag_w(input int num_sets, input int words_per_blk);
        return AW - 1 - $clog2(words_per_blk) - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Pipeline-side request/response and main-memory signals of the data cache.
interface dcache_if;
    import dcache_pkg::*;

    logic [1:0]    mem_control_in;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          stall_dcache;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;

    modport slave (
        input  mem_control_in, addr, wdata, mem_rdata, mem_rvalid,
        output rdata, stall_dcache, mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output mem_control_in, addr, wdata, mem_rdata, mem_rvalid,
        input  rdata, stall_dcache, mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_data_array.sv
// Cache data storage: one word-granular write port, one combinational read port.
module dcache_data_array
    import dcache_pkg::*;
#(
    parameter int NUM_SETS      = 32,
    parameter int WORDS_PER_BLK = 8
) (
    input  logic                              clk,
    input  logic                              we_i,
    input  logic [idx_w(NUM_SETS)-1:0]        widx_i,
    input  logic [off_w(WORDS_PER_BLK)-1:0]   woff_i,
    input  logic [DW-1:0]                     wdata_i,
    input  logic [idx_w(NUM_SETS)-1:0]        ridx_i,
    input  logic [off_w(WORDS_PER_BLK)-1:0]   roff_i,
    output logic [DW-1:0]                     rdata_o
);

    logic [DW-1:0] mem_q [NUM_SETS][WORDS_PER_BLK];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i][woff_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i][roff_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through/write-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_SETS      = 32,
    parameter int WORDS_PER_BLK = 8,
    parameter int MEM_LAT       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dcache_if.slave     bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int OFF_W = off_w(WORDS_PER_BLK);
    localparam int IDX_W = idx_w(NUM_SETS);
    localparam int TAG_W = tag_w(NUM_SETS, WORDS_PER_BLK);
    localparam logic [OFF_W:0] BLK_WORDS = (OFF_W+1)'(WORDS_PER_BLK);
    localparam logic [OFF_W:0] LAST_WORD = (OFF_W+1)'(WORDS_PER_BLK - 1);

    if ((1 << OFF_W) != WORDS_PER_BLK || (1 << IDX_W) != NUM_SETS ||
        OFF_W < 1 || IDX_W < 1 || TAG_W < 1 || MEM_LAT < 1) begin : g_bad_cfg
        $error("dcache_ctrl: unsupported parameter set");
    end

    state_e             state_q, state_d;
    logic [OFF_W:0]     req_cnt_q, req_cnt_d;
    logic [OFF_W:0]     resp_cnt_q, resp_cnt_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [NUM_SETS];
    logic [TAG_W-1:0]   tag_d [NUM_SETS];

    logic [OFF_W-1:0]   a_off;
    logic [IDX_W-1:0]   a_idx;
    logic [TAG_W-1:0]   a_tag;
    logic               addr_unused;
    logic               is_req, is_store, hit;
    logic               arr_we;
    logic [OFF_W-1:0]   arr_off;
    logic [DW-1:0]      arr_wdata, rd_word;
    logic               hit_ev, miss_ev;

    assign a_off       = bus.addr[OFF_W:1];
    assign a_idx       = bus.addr[OFF_W+IDX_W:OFF_W+1];
    assign a_tag       = bus.addr[AW-1:OFF_W+IDX_W+1];
    assign addr_unused = bus.addr[0];
    assign is_store    = bus.mem_control_in[MC_STORE];
    assign is_req      = bus.mem_control_in[MC_LOAD] | is_store;
    assign hit         = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

    dcache_data_array #(
        .NUM_SETS      (NUM_SETS),
        .WORDS_PER_BLK (WORDS_PER_BLK)
    ) u_data (
        .clk     (clk),
        .we_i    (arr_we),
        .widx_i  (a_idx),
        .woff_i  (arr_off),
        .wdata_i (arr_wdata),
        .ridx_i  (a_idx),
        .roff_i  (a_off),
        .rdata_o (rd_word)
    );

    always_comb begin
        state_d          = state_q;
        req_cnt_d        = req_cnt_q;
        resp_cnt_d       = resp_cnt_q;
        valid_d          = valid_q;
        tag_d            = tag_q;
        bus.rdata        = '0;
        bus.stall_dcache = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        arr_we           = 1'b0;
        arr_off          = a_off;
        arr_wdata        = bus.wdata;
        hit_ev           = 1'b0;
        miss_ev          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_req && hit) begin
                    hit_ev = 1'b1;
                    if (is_store) begin
                        arr_we        = 1'b1;
                        bus.mem_en    = 1'b1;
                        bus.mem_wr    = 1'b1;
                        bus.mem_addr  = bus.addr;
                        bus.mem_wdata = bus.wdata;
                    end else begin
                        bus.rdata = rd_word;
                    end
                end else if (is_req) begin
                    // Line is invalidated up front so a partial fill never looks like a hit.
                    miss_ev          = 1'b1;
                    bus.stall_dcache = 1'b1;
                    state_d          = FILL;
                    req_cnt_d        = '0;
                    resp_cnt_d       = '0;
                    valid_d[a_idx]   = 1'b0;
                end
            end
            FILL: begin
                bus.stall_dcache = 1'b1;
                if (req_cnt_q < BLK_WORDS) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = {a_tag, a_idx, req_cnt_q[OFF_W-1:0], 1'b0};
                    req_cnt_d    = req_cnt_q + 1'b1;
                end
                if (bus.mem_rvalid) begin
                    arr_we     = 1'b1;
                    arr_off    = resp_cnt_q[OFF_W-1:0];
                    arr_wdata  = bus.mem_rdata;
                    resp_cnt_d = resp_cnt_q + 1'b1;
                    if (resp_cnt_q == LAST_WORD) begin
                        valid_d[a_idx] = 1'b1;
                        tag_d[a_idx]   = a_tag;
                        state_d        = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
            valid_q    <= '0;
            for (int i = 0; i < NUM_SETS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            req_cnt_q  <= req_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // The hit that retires a filled request was already counted as a miss.
    logic        refill_q, refill_d;
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        refill_d   = (state_q == FILL) && (state_d == IDLE);
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_ev && !refill_q && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (miss_ev && miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            refill_q   <= refill_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a fixed-latency memory model.
module tb_dcache_ctrl;
    localparam int MEM_LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_if bus();

`ifdef DCACHE_PERF_CNT_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    dcache_ctrl #(
        .NUM_SETS      (32),
        .WORDS_PER_BLK (8),
        .MEM_LAT       (MEM_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    // Memory model: reads return mem_base + word offset MEM_LAT cycles later; not reset.
    logic [15:0] mem_base = 16'h0000;
    logic [MEM_LAT-1:0] pv = '0;
    logic [15:0] pa [MEM_LAT];
    int          cyc = 0;
    logic [15:0] rd_addr [$];
    int          rd_cyc [$];

    initial for (int i = 0; i < MEM_LAT; i++) pa[i] = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b0) begin
            rd_addr.push_back(bus.mem_addr);
            rd_cyc.push_back(cyc);
        end
        pv <= {pv[MEM_LAT-2:0], (bus.mem_en === 1'b1 && bus.mem_wr === 1'b0)};
        pa[0] <= bus.mem_addr;
        for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
    end

    assign bus.mem_rvalid = pv[MEM_LAT-1];
    assign bus.mem_rdata  = mem_base + 16'(pa[MEM_LAT-1][3:1]);

    int passed = 0;
    int total  = 0;

    task automatic issue(input logic [1:0] ctrl, input logic [15:0] a, input logic [15:0] wd);
        @(posedge clk);
        #1;
        bus.mem_control_in = ctrl;
        bus.addr           = a;
        bus.wdata          = wd;
    endtask

    task automatic wait_unstall(output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.stall_dcache !== 1'b1) break;
            n++;
            if (n >= 100) break;
        end
    endtask

    task automatic clear_log();
        rd_addr.delete();
        rd_cyc.delete();
    endtask

    task automatic test_reset();
        bus.mem_control_in = 2'b00;
        bus.addr           = 16'h0000;
        bus.wdata          = 16'h0000;
        rst_n              = 1'b0;
        #12;
        total++;
        if (bus.stall_dcache !== 1'b0 || bus.rdata !== 16'h0) $display("FAIL reset_outs stall=%b rdata=%h want 0/0000", bus.stall_dcache, bus.rdata);
        else passed++;
        total++;
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== 34'h0)
            $display("FAIL reset_mem en=%b wr=%b addr=%h wdata=%h want all 0", bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        else passed++;
`ifdef DCACHE_PERF_CNT_EN
        total++;
        if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) $display("FAIL reset_cnt hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt);
        else passed++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        int n;
        mem_base = 16'hA000;
        clear_log();
        issue(2'b10, 16'h0010, 16'h0000);
        wait_unstall(n);
        total++;
        if (n !== 13) $display("FAIL cold_stall got %0d want 13", n); else passed++;
        total++;
        if (rd_addr.size() !== 8) $display("FAIL cold_nreads got %0d want 8", rd_addr.size()); else passed++;
        for (int k = 0; k < 8 && k < rd_addr.size(); k++) begin
            total++;
            if (rd_addr[k] !== 16'h0010 + 16'(2*k) || rd_cyc[k] !== rd_cyc[0] + k)
                $display("FAIL cold_read%0d addr=%h cyc+%0d want %h cyc+%0d", k, rd_addr[k], rd_cyc[k]-rd_cyc[0], 16'h0010 + 16'(2*k), k);
            else passed++;
        end
        total++;
        if (bus.rdata !== 16'hA000 || bus.mem_en !== 1'b0) $display("FAIL cold_done rdata=%h en=%b want a000/0", bus.rdata, bus.mem_en);
        else passed++;
    endtask

    task automatic test_load_hit();
        issue(2'b10, 16'h0014, 16'h0000);
        @(negedge clk);
        total++;
        if (bus.stall_dcache !== 1'b0 || bus.rdata !== 16'hA002 || bus.mem_en !== 1'b0)
            $display("FAIL load_hit stall=%b rdata=%h en=%b want 0/a002/0", bus.stall_dcache, bus.rdata, bus.mem_en);
        else passed++;
        @(posedge clk);
        #1;
        bus.mem_control_in = 2'b00;
`ifdef DCACHE_PERF_CNT_EN
        total++;
        if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) $display("FAIL perf_cnt hit=%0d miss=%0d want 1/1", hit_cnt, miss_cnt);
        else passed++;
`endif
    endtask

    task automatic test_store_hit();
        issue(2'b01, 16'h0012, 16'hBEEF);
        @(negedge clk);
        total++;
        if ({bus.stall_dcache, bus.mem_en, bus.mem_wr} !== 3'b011 || bus.mem_addr !== 16'h0012 || bus.mem_wdata !== 16'hBEEF || bus.rdata !== 16'h0)
            $display("FAIL store_hit stall=%b en=%b wr=%b addr=%h wdata=%h rdata=%h want 0/1/1/0012/beef/0000",
                     bus.stall_dcache, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.rdata);
        else passed++;
        issue(2'b10, 16'h0012, 16'h0000);
        @(negedge clk);
        total++;
        if (bus.rdata !== 16'hBEEF || bus.mem_en !== 1'b0) $display("FAIL store_readback rdata=%h en=%b want beef/0", bus.rdata, bus.mem_en);
        else passed++;
        issue(2'b11, 16'h0016, 16'h5555);
        @(negedge clk);
        total++;
        if ({bus.stall_dcache, bus.mem_en, bus.mem_wr} !== 3'b011 || bus.mem_addr !== 16'h0016 || bus.mem_wdata !== 16'h5555 || bus.rdata !== 16'h0)
            $display("FAIL ctrl11_store stall=%b en=%b wr=%b addr=%h wdata=%h rdata=%h want 0/1/1/0016/5555/0000",
                     bus.stall_dcache, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.rdata);
        else passed++;
        issue(2'b10, 16'h0016, 16'h0000);
        @(negedge clk);
        total++;
        if (bus.rdata !== 16'h5555) $display("FAIL ctrl11_readback rdata=%h want 5555", bus.rdata); else passed++;
        issue(2'b00, 16'h0014, 16'h7777);
        @(negedge clk);
        total++;
        if ({bus.stall_dcache, bus.mem_en, bus.mem_wr} !== 3'b000 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0 || bus.rdata !== 16'h0)
            $display("FAIL no_request stall=%b en=%b wr=%b addr=%h wdata=%h rdata=%h want all 0",
                     bus.stall_dcache, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.rdata);
        else passed++;
    endtask

    task automatic test_conflict();
        int n;
        mem_base = 16'hC000;
        issue(2'b10, 16'h0210, 16'h0000);
        wait_unstall(n);
        total++;
        if (n !== 13 || bus.rdata !== 16'hC000) $display("FAIL conflict_fill stall=%0d rdata=%h want 13/c000", n, bus.rdata);
        else passed++;
        mem_base = 16'hA000;
        issue(2'b10, 16'h0010, 16'h0000);
        wait_unstall(n);
        total++;
        if (n !== 13 || bus.rdata !== 16'hA000) $display("FAIL conflict_evict stall=%0d rdata=%h want 13/a000", n, bus.rdata);
        else passed++;
    endtask

    task automatic test_store_miss();
        int n;
        mem_base = 16'hD000;
        clear_log();
        issue(2'b01, 16'h0420, 16'h1234);
        wait_unstall(n);
        total++;
        if (n !== 13) $display("FAIL smiss_stall got %0d want 13", n); else passed++;
        total++;
        if ({bus.mem_en, bus.mem_wr} !== 2'b11 || bus.mem_addr !== 16'h0420 || bus.mem_wdata !== 16'h1234)
            $display("FAIL smiss_wthru en=%b wr=%b addr=%h wdata=%h want 1/1/0420/1234", bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        else passed++;
        total++;
        if (rd_addr.size() !== 8 || rd_addr[0] !== 16'h0420 || rd_addr[7] !== 16'h042E)
            $display("FAIL smiss_reads n=%0d first=%h last=%h want 8/0420/042e", rd_addr.size(),
                     (rd_addr.size() > 0) ? rd_addr[0] : 16'hxxxx, (rd_addr.size() > 7) ? rd_addr[7] : 16'hxxxx);
        else passed++;
        issue(2'b10, 16'h0420, 16'h0000);
        @(negedge clk);
        total++;
        if (bus.rdata !== 16'h1234) $display("FAIL smiss_readback rdata=%h want 1234", bus.rdata); else passed++;
        issue(2'b10, 16'h0422, 16'h0000);
        @(negedge clk);
        total++;
        if (bus.rdata !== 16'hD001) $display("FAIL smiss_neighbour rdata=%h want d001", bus.rdata); else passed++;
    endtask

    task automatic test_reset_mid_fill();
        int n;
        bit bad;
        mem_base = 16'hE000;
        issue(2'b10, 16'h0810, 16'h0000);
        @(negedge clk);
        repeat (5) @(negedge clk);
        total++;
        if (bus.stall_dcache !== 1'b1) $display("FAIL rst_pre stall=%b want 1", bus.stall_dcache); else passed++;
        rst_n = 1'b0;
        bus.mem_control_in = 2'b00;
        #1;
        total++;
        if (bus.stall_dcache !== 1'b0 || bus.mem_en !== 1'b0) $display("FAIL rst_now stall=%b en=%b want 0/0", bus.stall_dcache, bus.mem_en);
        else passed++;
`ifdef DCACHE_PERF_CNT_EN
        total++;
        if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) $display("FAIL rst_cnt hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt);
        else passed++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.stall_dcache !== 1'b0 || bus.mem_en !== 1'b0 || bus.rdata !== 16'h0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL rst_idle activity seen=1 want 0"); else passed++;
        mem_base = 16'hD000;
        issue(2'b10, 16'h0420, 16'h0000);
        wait_unstall(n);
        total++;
        if (n !== 13 || bus.rdata !== 16'hD000) $display("FAIL rst_cleared stall=%0d rdata=%h want 13/d000", n, bus.rdata);
        else passed++;
        mem_base = 16'hE000;
        issue(2'b10, 16'h0810, 16'h0000);
        wait_unstall(n);
        total++;
        if (n !== 13 || bus.rdata !== 16'hE000) $display("FAIL rst_reload stall=%0d rdata=%h want 13/e000", n, bus.rdata);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_load_hit();
        test_store_hit();
        test_conflict();
        test_store_miss();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, write-allocate data cache for the MEM stage of the 16-bit pipeline. It consumes the memory request latched in the EX/MEM pipeline register (address, write data, memory control) and produces `stall_dcache`, which freezes the front of the pipeline. On a miss it fills one block from pipelined main memory. It returns load data to the MEM/WB path.

## Interface
- `NUM_SETS`, 32: number of cache lines; power of two.
- `WORDS_PER_BLK`, 8: 16-bit words per block; power of two.
- `MEM_LAT`, 4: main-memory read latency, in cycles from request to `mem_rvalid`.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_control_in`  in  2  bit1 = load request, bit0 = store request.
- `addr`  in  16  byte address (ALU result); bit0 ignored.
- `wdata`  in  16  store data.
- `rdata`  out  16  load data; valid when a load hits.
- `stall_dcache`  out  1  pipeline hold request.
- `mem_en`  out  1  main-memory request strobe.
- `mem_wr`  out  1  1 = write, 0 = read.
- `mem_addr`  out  16  main-memory byte address.
- `mem_wdata`  out  16  main-memory write data.
- `mem_rdata`  in  16  main-memory read data.
- `mem_rvalid`  in  1  read data valid. Responses arrive in order.

## Operation
- Address split, with default parameters:
  - word offset = `addr[3:1]`
  - index = `addr[8:4]`
  - tag = `addr[15:9]`
  - Field widths derive from the parameters.
- `mem_control_in == 2'b11` is treated as a store. `2'b00` is no request.
- Per-line state: valid bit, tag, and data words.
- FSM states:
  - IDLE:
    - Hit (valid and tag match) on a load: `rdata` = cached word, combinational in the same cycle; `stall_dcache` = 0.
    - Hit on a store: update the cached word at the clock edge. Issue a write-through in the same cycle: `mem_en`=1, `mem_wr`=1, `mem_addr`=`addr`, `mem_wdata`=`wdata`. `stall_dcache` = 0.
    - Miss on any request: `stall_dcache` = 1; go to FILL. Clear the request and response counters.
  - FILL:
    - `stall_dcache` = 1.
    - Request counter: while it is below `WORDS_PER_BLK`, issue one read per cycle. `mem_addr` = {tag, index, req_cnt, 1'b0}; the counter then increments.
    - Response counter: each `mem_rvalid` writes `mem_rdata` to word resp_cnt of the line.
    - On the last response: set valid, write the tag, go to IDLE.
    - The request then re-evaluates as a hit. A store miss completes as a store hit, including the write-through.
- `mem_rvalid` is ignored in IDLE.
- Outputs when there is no hit: `rdata` = 0. With no memory request, `mem_en`=0, `mem_wr`=0, and `mem_addr`/`mem_wdata` = 0.
- No writebacks; every line is always clean.

## Timing
- Reset values: `stall_dcache`=0, `rdata`=0, `mem_en`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0. State is IDLE, all valid bits are 0, and the counters are 0.
- Hit: zero added latency; `stall_dcache` is never asserted.
- Miss detected in cycle 0:
  - Reads are issued in cycles 1..`WORDS_PER_BLK`.
  - The last response arrives in cycle `WORDS_PER_BLK`+`MEM_LAT`.
  - The hit completes in the next cycle.
  - `stall_dcache` is high for exactly `WORDS_PER_BLK`+`MEM_LAT`+1 cycles (13 with defaults).
- Inputs must be held stable while `stall_dcache`=1; the EX/MEM register is frozen by that signal.
- Reset asserted mid-fill: return to IDLE immediately and clear all valid bits. The partial line stays invalid. Late `mem_rvalid` pulses are ignored.

## Configuration
- `DCACHE_PERF_CNT_EN`
  - Defined: adds outputs `hit_cnt[15:0]` and `miss_cnt[15:0]`.
    - `hit_cnt` increments once per hit on the cycle the request completes without stall.
    - `miss_cnt` increments once per miss, in IDLE on the transition to FILL. The completing hit after a fill does not count as a hit.
    - Both saturate at 0xFFFF and reset to 0.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- `dcache_pkg` holds:
  - the FSM state enum (IDLE, FILL)
  - the `mem_control` bit positions (LOAD=1, STORE=0)
  - the derived offset/index/tag width functions
- Sub-module `dcache_data_array` holds the data storage: a `NUM_SETS`×`WORDS_PER_BLK`×16 array with one write port (word enable) and one combinational read port.
- Tags, valid bits, FSM and counters stay in `dcache_ctrl`.

## Test plan
- Cold load miss:
  - Stimulus: after reset, load 0x0010; memory returns 0xA000+k for word k.
  - Expect: stall for 13 cycles; 8 reads to 0x0010..0x001E, one per cycle; then `rdata`=0xA000 with stall 0.
- Load hit: then load 0x0014.
  - Expect: `stall_dcache`=0 and `rdata`=0xA002 in the same cycle; `mem_en`=0.
- Store hit: store 0xBEEF to 0x0012.
  - Expect: no stall; `mem_en`=1, `mem_wr`=1, `mem_addr`=0x0012, `mem_wdata`=0xBEEF.
  - Expect: a subsequent load of 0x0012 returns 0xBEEF.
- Conflict eviction:
  - Load 0x0210 (index 1, tag 1): expect a 13-cycle miss.
  - Then load 0x0010: expect it to miss again.
- Store miss: store 0x1234 to 0x0420.
  - Expect: fill of 0x0420..0x042E, then a write-through of 0x1234 to 0x0420 in the first cycle with stall 0.
- Reset mid-fill:
  - Stimulus: assert `rst_n`=0 in fill cycle 5.
  - Expect: `stall_dcache`=0 immediately; late `mem_rvalid` pulses are ignored; a reload of the same address misses (13 cycles).
  - With `DCACHE_PERF_CNT_EN` defined: counters reset to 0.
